// File: rtl/demux1_16_deserializer_pkg.sv
// Shared definitions for the 1:16 serial-to-parallel demultiplexer:
// the auto-frame state encoding and the default lane geometry.
package demux1_16_deserializer_pkg;

  localparam int LANES_DEF = 16;
  localparam int SEL_W_DEF = 4;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_e;

endpackage

// File: rtl/demux1_16_deserializer_lane_counter.sv
// Auto-mode lane pointer. A clear with enable in the same cycle means the
// frame-opening bit has already gone to lane 0, so the pointer moves to 1.
module lane_counter
  import demux1_16_deserializer_pkg::*;
#(
  parameter int SEL_W = SEL_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [SEL_W-1:0] cnt,
  output logic             tc
);

  logic [SEL_W-1:0] cnt_r;

  // lane pointer register: clear has priority, increment wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {SEL_W{1'b0}};
    end else if (clr) begin
      cnt_r <= en ? {{(SEL_W-1){1'b0}}, 1'b1} : {SEL_W{1'b0}};
    end else if (en) begin
      cnt_r <= cnt_r + {{(SEL_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;
  assign tc  = (cnt_r == {SEL_W{1'b1}});

endmodule

// File: rtl/demux1_16_deserializer.sv
// Serial bit demultiplexer onto LANES registered lanes, steered either by the
// select input (manual) or by an internal lane counter framed by frame_start.
module demux1_16_deserializer
  import demux1_16_deserializer_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int SEL_W = SEL_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in,
  input  logic             in_valid,
  input  logic [SEL_W-1:0] select,
  input  logic             auto_mode,
  input  logic             frame_start,
  output logic [LANES-1:0] y,
  output logic [LANES-1:0] lane_valid,
  output logic             busy,
  output logic             frame_done
);

  state_e           state_r;
  logic             busy_r;
  logic             done_r;
  logic [LANES-1:0] y_r;
  logic [LANES-1:0] lv_r;

  logic [SEL_W-1:0] cnt_s;
  logic             tc_s;
  logic             cnt_clr_s;
  logic             cnt_en_s;
  logic             wr_s;
  logic             clear_lv_s;
  logic [SEL_W-1:0] wr_idx_s;
  logic [LANES-1:0] wr_mask_s;
  logic [LANES-1:0] y_nxt_s;
  logic [LANES-1:0] lv_nxt_s;

  lane_counter #(
    .SEL_W(SEL_W)
  ) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (cnt_clr_s),
    .en   (cnt_en_s),
    .cnt  (cnt_s),
    .tc   (tc_s)
  );

  // write steering: which lane (if any) takes the bit, and whether flags clear
  always_comb begin
    cnt_clr_s  = 1'b0;
    cnt_en_s   = 1'b0;
    wr_s       = 1'b0;
    clear_lv_s = 1'b0;
    wr_idx_s   = select;
    if (auto_mode) begin
      if (frame_start) begin
        cnt_clr_s  = 1'b1;
        clear_lv_s = 1'b1;
        wr_s       = in_valid;
        cnt_en_s   = in_valid;
        wr_idx_s   = {SEL_W{1'b0}};
      end else if (state_r == COLLECT) begin
        wr_s     = in_valid;
        cnt_en_s = in_valid;
        wr_idx_s = cnt_s;
      end else begin
        // auto IDLE: serial data is dropped until a frame is opened
        wr_s     = 1'b0;
        cnt_en_s = 1'b0;
      end
    end else begin
      clear_lv_s = frame_start;
      wr_s       = in_valid;
      wr_idx_s   = select;
    end
  end

  // lane datapath next values: clear happens before the same-cycle write sets its flag
  always_comb begin
    if (wr_s) begin
      wr_mask_s = {{(LANES-1){1'b0}}, 1'b1} << wr_idx_s;
    end else begin
      wr_mask_s = {LANES{1'b0}};
    end
    lv_nxt_s = (clear_lv_s ? {LANES{1'b0}} : lv_r) | wr_mask_s;
    y_nxt_s  = (y_r & ~wr_mask_s) | ({LANES{in}} & wr_mask_s);
  end

  // lane value and written-flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_r  <= {LANES{1'b0}};
      lv_r <= {LANES{1'b0}};
    end else begin
      y_r  <= y_nxt_s;
      lv_r <= lv_nxt_s;
    end
  end

  // auto-frame FSM with registered busy and single-cycle frame_done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (!auto_mode) begin
        state_r <= IDLE;
        busy_r  <= 1'b0;
      end else if (frame_start) begin
        // a restart mid-frame never reports completion of the abandoned frame
        state_r <= COLLECT;
        busy_r  <= 1'b1;
      end else begin
        case (state_r)
          IDLE: begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
          COLLECT: begin
            if (in_valid && tc_s) begin
              state_r <= IDLE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              state_r <= COLLECT;
              busy_r  <= 1'b1;
            end
          end
          default: begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign y          = y_r;
  assign lane_valid = lv_r;
  assign busy       = busy_r;
  assign frame_done = done_r;

endmodule

// File: tb/tb_demux1_16_deserializer.sv
// Randomized self-checking bench for demux1_16_deserializer against a
// behavioural frame model (lane arrays plus a frame position counter).
module tb_demux1_16_deserializer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in;
  logic        in_valid;
  logic [3:0]  select;
  logic        auto_mode;
  logic        frame_start;
  logic [15:0] y;
  logic [15:0] lane_valid;
  logic        busy;
  logic        frame_done;

  int checks    = 0;
  int failures  = 0;
  int fd_pulses = 0;

  // reference model state
  bit [15:0] y_m;
  bit [15:0] lv_m;
  bit        coll_m;
  bit        fd_m;
  int        pos_m;

  always #5 clk = ~clk;

  demux1_16_deserializer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in         (in),
    .in_valid   (in_valid),
    .select     (select),
    .auto_mode  (auto_mode),
    .frame_start(frame_start),
    .y          (y),
    .lane_valid (lane_valid),
    .busy       (busy),
    .frame_done (frame_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    y_m    = 16'h0000;
    lv_m   = 16'h0000;
    coll_m = 1'b0;
    fd_m   = 1'b0;
    pos_m  = 0;
  endtask

  // one clock edge of the intended behaviour, in frame terms
  task automatic model_step(input bit i, input bit iv, input bit [3:0] s, input bit am, input bit fs);
    fd_m = 1'b0;
    if (am) begin
      if (fs) begin
        lv_m   = 16'h0000;
        coll_m = 1'b1;
        pos_m  = 0;
        if (iv) begin
          y_m[0]  = i;
          lv_m[0] = 1'b1;
          pos_m   = 1;
        end
      end else if (coll_m && iv) begin
        y_m[pos_m]  = i;
        lv_m[pos_m] = 1'b1;
        pos_m       = pos_m + 1;
        if (pos_m == 16) begin
          coll_m = 1'b0;
          pos_m  = 0;
          fd_m   = 1'b1;
        end
      end
    end else begin
      coll_m = 1'b0;
      if (fs) lv_m = 16'h0000;
      if (iv) begin
        y_m[s]  = i;
        lv_m[s] = 1'b1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".y"}, {16'h0000, y}, {16'h0000, y_m});
    chk({tag, ".lane_valid"}, {16'h0000, lane_valid}, {16'h0000, lv_m});
    chk({tag, ".busy"}, {31'd0, busy}, {31'd0, coll_m});
    chk({tag, ".frame_done"}, {31'd0, frame_done}, {31'd0, fd_m});
  endtask

  // drive one cycle of inputs, advance one edge, compare one time unit later
  task automatic step(input string tag, input bit i, input bit iv, input bit [3:0] s,
                      input bit am, input bit fs);
    in          = i;
    in_valid    = iv;
    select      = s;
    auto_mode   = am;
    frame_start = fs;
    @(posedge clk);
    model_step(i, iv, s, am, fs);
    #1;
    if (frame_done === 1'b1) fd_pulses++;
    check_all(tag);
  endtask

  task automatic async_reset_pulse(input string tag);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    bit [15:0] pat;
    rst_n       = 1'b0;
    in          = 1'b0;
    in_valid    = 1'b0;
    select      = 4'd0;
    auto_mode   = 1'b0;
    frame_start = 1'b0;
    model_reset();

    // reset held with random inputs
    for (int k = 0; k < 4; k++) begin
      in          = 1'($urandom);
      in_valid    = 1'($urandom);
      select      = 4'($urandom);
      auto_mode   = 1'($urandom);
      frame_start = 1'($urandom);
      @(posedge clk);
      #1;
      check_all("reset");
    end
    rst_n = 1'b1;

    // manual sweep
    pat       = 16'hA5A5;
    fd_pulses = 0;
    for (int k = 0; k < 16; k++) step("manual", pat[k], 1'b1, 4'(k), 1'b0, 1'b0);
    chk("manual.y_final", {16'h0000, y}, 32'h0000_A5A5);
    chk("manual.lv_final", {16'h0000, lane_valid}, 32'h0000_FFFF);
    chk("manual.no_done", fd_pulses, 32'd0);

    // auto frame with idle gaps
    pat       = 16'h5A3C;
    fd_pulses = 0;
    step("auto.start", 1'b0, 1'b0, 4'($urandom), 1'b1, 1'b1);
    for (int k = 0; k < 16; k++) begin
      step("auto.bit", pat[k], 1'b1, 4'($urandom), 1'b1, 1'b0);
      if (k < 15) step("auto.gap", 1'($urandom), 1'b0, 4'($urandom), 1'b1, 1'b0);
    end
    chk("auto.done_at_end", {31'd0, frame_done}, 32'd1);
    chk("auto.busy_fell", {31'd0, busy}, 32'd0);
    chk("auto.y_final", {16'h0000, y}, 32'h0000_5A3C);
    step("auto.after", 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    chk("auto.one_done", fd_pulses, 32'd1);

    // restart mid-frame with frame_start and in_valid together
    fd_pulses = 0;
    step("restart.start", 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    for (int k = 0; k < 7; k++) step("restart.bit", 1'b1, 1'b1, 4'd0, 1'b1, 1'b0);
    step("restart.fs_iv", 1'b1, 1'b1, 4'd0, 1'b1, 1'b1);
    chk("restart.lv", {16'h0000, lane_valid}, 32'h0000_0001);
    for (int k = 0; k < 15; k++) step("restart.bit2", 1'b1, 1'b1, 4'd0, 1'b1, 1'b0);
    chk("restart.done_end", {31'd0, frame_done}, 32'd1);
    step("restart.after", 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    chk("restart.one_done", fd_pulses, 32'd1);
    chk("restart.y", {16'h0000, y}, 32'h0000_FFFF);

    // async reset after 5 bits, then auto IDLE must ignore in_valid
    fd_pulses = 0;
    step("areset.start", 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) step("areset.bit", 1'b1, 1'b1, 4'd0, 1'b1, 1'b0);
    async_reset_pulse("areset.now");
    step("areset.idle_ignore", 1'b1, 1'b1, 4'd3, 1'b1, 1'b0);
    chk("areset.busy", {31'd0, busy}, 32'd0);
    chk("areset.y", {16'h0000, y}, 32'h0000_0000);
    chk("areset.no_done", fd_pulses, 32'd0);

    // abort by dropping auto_mode after 9 bits
    fd_pulses = 0;
    step("abort.start", 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    for (int k = 0; k < 9; k++) step("abort.bit", 1'($urandom), 1'b1, 4'd0, 1'b1, 1'b0);
    step("abort.drop", 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    chk("abort.busy", {31'd0, busy}, 32'd0);
    chk("abort.lv", {16'h0000, lane_valid}, 32'h0000_01FF);
    step("abort.after", 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    chk("abort.no_done", fd_pulses, 32'd0);

    // randomized mixed traffic with occasional asynchronous resets
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 499) == 0) async_reset_pulse("rand.reset");
      step("rand", 1'($urandom), ($urandom_range(0, 2) != 0), 4'($urandom),
           ($urandom_range(0, 15) != 0), ($urandom_range(0, 24) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
